flit_arbiter_4x1: RTL

FLIT_ARBITER_4X1 -- requirements
Module: flit_arbiter_4x1

---
 rtl/flit_arbiter_4x1.sv | 124 ++++++++++++
 1 files changed

// File: rtl/flit_arbiter_4x1.sv
// 4:1 round-robin flit arbiter with packet lock and a single output register.
// A port keeps the lock until its tail flit transfers; other ports wait.
module flit_arbiter_4x1 #(
    parameter int FLIT_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            in_valid,
    input  logic [FLIT_WIDTH-1:0] in_flit0,
    input  logic [FLIT_WIDTH-1:0] in_flit1,
    input  logic [FLIT_WIDTH-1:0] in_flit2,
    input  logic [FLIT_WIDTH-1:0] in_flit3,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [FLIT_WIDTH-1:0] out_flit,
    input  logic                  out_ready,
    output logic [1:0]            select,
    output logic [3:0]            grant
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                r_state;
    logic [1:0]            r_last;
    logic [1:0]            r_select;
    logic [3:0]            r_grant;
    logic                  r_out_valid;
    logic [FLIT_WIDTH-1:0] r_out_flit;

    logic [1:0]            w_pick;
    logic                  w_found;
    logic [FLIT_WIDTH-1:0] w_sel_flit;
    logic                  w_can_accept;
    logic [3:0]            w_in_ready;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_tail;

    // Search starts just after the last owner, so the last owner ranks lowest.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && in_valid[r_last + 2'(k)]) begin
                w_pick  = r_last + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_flit = in_flit0;
        case (r_select)
            2'd0: w_sel_flit = in_flit0;
            2'd1: w_sel_flit = in_flit1;
            2'd2: w_sel_flit = in_flit2;
            2'd3: w_sel_flit = in_flit3;
            default: w_sel_flit = in_flit0;
        endcase
    end

    assign w_can_accept = !r_out_valid || out_ready;

    always_comb begin
        w_in_ready = 4'b0000;
        if (r_state == LOCKED) begin
            w_in_ready[r_select] = w_can_accept;
        end
    end

    assign w_in_xfer  = in_valid[r_select] && w_in_ready[r_select];
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_tail     = w_sel_flit[FLIT_WIDTH-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_last   <= 2'd3;
            r_select <= 2'd0;
            r_grant  <= 4'b0000;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_grant <= 4'b0000;
                    if (w_found) begin
                        r_select <= w_pick;
                        r_grant  <= 4'b0001 << w_pick;
                        r_state  <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_in_xfer && w_tail) begin
                        r_last  <= r_select;
                        r_grant <= 4'b0000;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Output register drains regardless of the arbitration state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_flit  <= w_sel_flit;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign select    = r_select;
    assign grant     = r_grant;

endmodule
